// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : RV32I data-memory responder (block RAM, LED/switch MMIO)
// Rev 1.0
// ============================================================================
module dmem_ctrl #(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] MMIO_BASE = 32'hFFFFFC00,
   parameter logic [9:0]  LED_OFF   = 10'h060,
   parameter logic [9:0]  SW_OFF    = 10'h070
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw,
   output logic [15:0]       led
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [15:0] r_led;
   logic [15:0] r_sw_meta, r_sw_sync;

   logic        w_accept, w_is_mmio, w_f3_ok, w_misalign, w_range_err, w_err;
   logic        w_ram_acc, w_led_wr;
   logic [3:0]  w_lanes;
   logic [31:0] w_mmio_word, w_mmio_rdata;

   function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(w >> {off, 3'b000});
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'd0, b};
         3'b101:  res = {16'd0, h};
         default: res = w;
      endcase
      return res;
   endfunction

   always_comb begin
      w_accept    = (r_state == S_IDLE) && req_valid;
      w_is_mmio   = (req_addr[31:10] == MMIO_BASE[31:10]);
      w_range_err = !w_is_mmio && (req_addr[31:ADDR_W+2] != '0);
      if (req_we) w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else        w_f3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
      w_misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      w_err       = !w_f3_ok || w_misalign || w_range_err;
      w_ram_acc   = w_accept && !w_err && !w_is_mmio;
      w_led_wr    = w_accept && !w_err && w_is_mmio && req_we &&
                    (req_funct3 == 3'b010) && (req_addr[9:0] == LED_OFF);

      case (req_funct3[1:0])
         2'b00:   begin w_lanes = 4'b0001 << req_addr[1:0]; ram_wdata = {4{req_wdata[7:0]}};  end
         2'b01:   begin w_lanes = 4'b0011 << req_addr[1:0]; ram_wdata = {2{req_wdata[15:0]}}; end
         default: begin w_lanes = 4'b1111;                  ram_wdata = req_wdata;            end
      endcase
      ram_en   = w_ram_acc;
      ram_we   = (w_ram_acc && req_we) ? w_lanes : 4'b0000;
      ram_addr = req_addr[ADDR_W+1:2];

      // Switch register reads are always unsigned; only the lane selection follows funct3
      w_mmio_word  = (req_addr[9:2] == SW_OFF[9:2]) ? {16'd0, r_sw_sync} : 32'd0;
      w_mmio_rdata = f_extract(w_mmio_word,
                               (req_funct3 == 3'b010) ? req_funct3 : {1'b1, req_funct3[1:0]},
                               req_addr[1:0]);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_state_nxt = (w_err || w_is_mmio || req_we) ? S_RESP : S_RD;
         S_RD:    w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_funct3  <= 3'd0;
         r_off     <= 2'd0;
         r_err     <= 1'b0;
         r_rdata   <= 32'd0;
         r_led     <= 16'd0;
         r_sw_meta <= 16'd0;
         r_sw_sync <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
         if (w_led_wr) r_led <= req_wdata[15:0];
         if (w_accept) begin
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_err    <= w_err;
            if (w_err)                      r_rdata <= 32'd0;
            else if (w_is_mmio && !req_we)  r_rdata <= w_mmio_rdata;
         end
         if (r_state == S_RD) r_rdata <= f_extract(ram_rdata, r_funct3, r_off);
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_err   = r_err && (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign led       = r_led;

endmodule
`default_nettype wire
